// File: rtl/chacha_pkg.sv
// Shared types, constants and quarter-round index tables for the ChaCha20 block core.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t chacha_state_t [16];

  localparam word_t SIGMA0 = 32'h61707865;
  localparam word_t SIGMA1 = 32'h3320646e;
  localparam word_t SIGMA2 = 32'h79622d32;
  localparam word_t SIGMA3 = 32'h6b206574;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Word indices (a,b,c,d) fed to each of the four quarter rounds.
  localparam int unsigned COL_IDX [4][4] = '{
    '{0, 4,  8, 12},
    '{1, 5,  9, 13},
    '{2, 6, 10, 14},
    '{3, 7, 11, 15}
  };

  localparam int unsigned DIAG_IDX [4][4] = '{
    '{0, 5, 10, 15},
    '{1, 6, 11, 12},
    '{2, 7,  8, 13},
    '{3, 4,  9, 14}
  };

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter round: add/xor/rotate chain with 16/12/8/7 rotates.
module chacha_quarter_round #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out
);

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned s);
    return (x << s) | (x >> (WIDTH - s));
  endfunction

  logic [WIDTH-1:0] a1, b1, c1, d1;
  logic [WIDTH-1:0] a2, b2, c2, d2;

  always_comb begin
    a1 = a_in + b_in;
    d1 = rotl(d_in ^ a1, 16);
    c1 = c_in + d1;
    b1 = rotl(b_in ^ c1, 12);
    a2 = a1 + b1;
    d2 = rotl(d1 ^ a2, 8);
    c2 = c1 + d2;
    b2 = rotl(b1 ^ c2, 7);
  end

  assign a_out = a2;
  assign b_out = b2;
  assign c_out = c2;
  assign d_out = d2;

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one full round per cycle through four quarter rounds,
// then feed-forward add of the initial state onto a valid/ready keystream output.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [8*WIDTH-1:0]   key,
  input  logic [3*WIDTH-1:0]   nonce,
  input  logic [WIDTH-1:0]     counter,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [16*WIDTH-1:0]  keystream,
  output logic                 busy
);

  localparam int RCW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  state_e        state_q, state_d;
  logic [RCW-1:0] round_cnt_q;
  chacha_state_t init_q, work_q, ks_q;
  chacha_state_t start_state, work_rnd;
  logic          ks_valid_q;
  word_t         q_in  [4][4];
  word_t         q_out [4][4];
  logic          last_round;

  assign last_round = (round_cnt_q == RCW'(ROUNDS - 1));

  always_comb begin
    start_state[0] = SIGMA0;
    start_state[1] = SIGMA1;
    start_state[2] = SIGMA2;
    start_state[3] = SIGMA3;
    for (int k = 0; k < 8; k++) start_state[4+k] = key[32*k +: 32];
    start_state[12] = counter;
    for (int n = 0; n < 3; n++) start_state[13+n] = nonce[32*n +: 32];
  end

  // Only round_cnt[0] selects between column and diagonal grouping.
  always_comb begin
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++)
        q_in[g][k] = round_cnt_q[0] ? work_q[DIAG_IDX[g][k]] : work_q[COL_IDX[g][k]];
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_quarter_round #(.WIDTH(WIDTH)) u_qr (
      .a_in  (q_in[g][0]),
      .b_in  (q_in[g][1]),
      .c_in  (q_in[g][2]),
      .d_in  (q_in[g][3]),
      .a_out (q_out[g][0]),
      .b_out (q_out[g][1]),
      .c_out (q_out[g][2]),
      .d_out (q_out[g][3])
    );
  end

  always_comb begin
    work_rnd = work_q;
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++)
        if (round_cnt_q[0]) work_rnd[DIAG_IDX[g][k]] = q_out[g][k];
        else                work_rnd[COL_IDX[g][k]]  = q_out[g][k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = ROUND;
      ROUND:   if (last_round)  state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (ks_ready)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt_q <= '0;
      init_q      <= '{default: '0};
      work_q      <= '{default: '0};
      ks_q        <= '{default: '0};
      ks_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_valid) begin
          init_q      <= start_state;
          work_q      <= start_state;
          round_cnt_q <= '0;
        end
        ROUND: begin
          work_q      <= work_rnd;
          round_cnt_q <= round_cnt_q + 1'b1;
        end
        FINAL: begin
          for (int i = 0; i < 16; i++) ks_q[i] <= work_q[i] + init_q[i];
          ks_valid_q <= 1'b1;
        end
        DONE: if (ks_ready) ks_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) keystream[32*i +: 32] = ks_q[i];
  end

  assign ks_valid = ks_valid_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Randomized self-checking bench for chacha_block_core against a software ChaCha model.
module tb_chacha_block_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid, start_ready, ks_valid, ks_ready, busy;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic [511:0] keystream;

  logic         start_valid8, start_ready8, ks_valid8, ks_ready8, busy8;
  logic [511:0] keystream8;

  logic [31:0]  qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chacha_block_core #(.ROUNDS(20), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .key(key), .nonce(nonce), .counter(counter), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .keystream(keystream), .busy(busy)
  );

  chacha_block_core #(.ROUNDS(8), .WIDTH(32)) dut8 (
    .clk(clk), .rst(rst), .start_valid(start_valid8), .start_ready(start_ready8),
    .key(key), .nonce(nonce), .counter(counter), .ks_valid(ks_valid8),
    .ks_ready(ks_ready8), .keystream(keystream8), .busy(busy8)
  );

  chacha_quarter_round #(.WIDTH(32)) u_qr (
    .a_in(qa), .b_in(qb), .c_in(qc), .d_in(qd),
    .a_out(qa_o), .b_out(qb_o), .c_out(qc_o), .d_out(qd_o)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Software reference: RFC 8439 block function with plain arrays.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [127:0] qr_ref(input logic [31:0] a, b, c, d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c, input int rounds);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] out;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int r = 0; r < rounds / 2; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr_ref(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr_ref(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr_ref(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr_ref(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr_ref(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr_ref(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr_ref(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr_ref(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) out[32*i +: 32] = x[i] + s[i];
    return out;
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request while the core is idle; consumes the accept edge.
  task automatic start_req(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    check("start_ready_before_req", 512'(start_ready), 512'(1'b1));
    key = k; nonce = n; counter = c; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (!ks_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic xfer();
    ks_ready = 1'b1;
    tick();
    ks_ready = 1'b0;
  endtask

  logic [31:0]  rfc_words [16] = '{
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2
  };
  logic [511:0] rfc_exp;
  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;

  initial begin
    int lat, accepts, nrec, cyc, dly;
    int t_rec [2];
    logic [511:0] ks_rec [2];
    logic [511:0] held;
    logic [255:0] rk;
    logic [95:0]  rn;
    logic [31:0]  rc;
    logic         will_accept;

    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    for (int i = 0; i < 16; i++) rfc_exp[32*i +: 32] = rfc_words[i];

    rst = 1'b1; start_valid = 1'b0; ks_ready = 1'b0; start_valid8 = 1'b0; ks_ready8 = 1'b0;
    key = '0; nonce = '0; counter = '0;
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #2;
    check("rst_ks_valid",    512'(ks_valid),    512'(1'b0));
    check("rst_busy",        512'(busy),        512'(1'b0));
    check("rst_start_ready", 512'(start_ready), 512'(1'b1));
    check("rst_keystream",   keystream,         '0);
    check("qr_vector", 512'({qa_o, qb_o, qc_o, qd_o}),
          512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));
    tick();
    rst = 1'b0;
    tick();

    // RFC vector, then hold backpressure for 10 cycles.
    start_req(rfc_key, rfc_nonce, 32'd1);
    lat = 0;
    wait_valid(lat);
    check("rfc_latency", 512'(lat), 512'(21));
    check("rfc_block",   keystream, rfc_exp);
    check("rfc_word0",   512'(keystream[31:0]),    512'(32'he4e7f110));
    check("rfc_word15",  512'(keystream[511:480]), 512'(32'h4e3c50a2));
    check("model_rfc",   ref_block(rfc_key, rfc_nonce, 32'd1, 20), rfc_exp);
    held = keystream;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_ks_stable",    keystream,         held);
      check("bp_valid_held",   512'(ks_valid),    512'(1'b1));
      check("bp_start_ready",  512'(start_ready), 512'(1'b0));
    end
    xfer();
    check("bp_valid_drop",   512'(ks_valid),    512'(1'b0));
    check("bp_ready_again",  512'(start_ready), 512'(1'b1));
    check("bp_ks_kept",      keystream,         held);

    // Request while busy must be ignored.
    rk = rand_key(); rn = {$urandom, $urandom, $urandom}; rc = $urandom;
    start_req(rk, rn, rc);
    lat = 0;
    for (int i = 0; i < 4; i++) begin tick(); lat++; end
    check("busy_no_ready", 512'(start_ready), 512'(1'b0));
    key = ~rk; nonce = ~rn; counter = rc + 32'd5; start_valid = 1'b1;
    tick(); lat++;
    start_valid = 1'b0;
    wait_valid(lat);
    check("busy_latency", 512'(lat), 512'(21));
    check("busy_ignored", keystream, ref_block(rk, rn, rc, 20));
    xfer();
    tick();
    check("busy_no_queue", 512'(busy), 512'(1'b0));

    // Back-to-back with ks_ready tied high and start_valid held.
    ks_ready = 1'b1; key = rfc_key; nonce = rfc_nonce; counter = 32'd1; start_valid = 1'b1;
    accepts = 0; nrec = 0; cyc = 0;
    while (nrec < 2 && cyc < 200) begin
      will_accept = start_valid && start_ready;
      tick(); cyc++;
      if (will_accept) begin
        accepts++;
        if (accepts == 1) counter = 32'd2;
        if (accepts == 2) start_valid = 1'b0;
      end
      if (ks_valid) begin
        t_rec[nrec] = cyc;
        ks_rec[nrec] = keystream;
        nrec++;
      end
    end
    start_valid = 1'b0;
    check("b2b_count",  512'(nrec), 512'(2));
    check("b2b_spacing", 512'(t_rec[1] - t_rec[0]), 512'(23));
    check("b2b_blk1",   ks_rec[0], rfc_exp);
    check("b2b_blk2",   ks_rec[1], ref_block(rfc_key, rfc_nonce, 32'd2, 20));
    tick();
    ks_ready = 1'b0;
    tick();

    // Random blocks with random downstream delay, including counter wrap value.
    for (int t = 0; t < 8; t++) begin
      rk = rand_key(); rn = {$urandom, $urandom, $urandom};
      rc = (t == 0) ? 32'hffffffff : $urandom;
      start_req(rk, rn, rc);
      lat = 0;
      wait_valid(lat);
      check("rand_latency", 512'(lat), 512'(21));
      check("rand_block",   keystream, ref_block(rk, rn, rc, 20));
      held = keystream;
      dly = $urandom_range(3, 0);
      for (int i = 0; i < dly; i++) tick();
      check("rand_hold", keystream, held);
      xfer();
    end

    // Reset in the middle of round 7.
    start_req(rand_key(), 96'h1, 32'd3);
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy_before", 512'(busy), 512'(1'b1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  512'(ks_valid),    512'(1'b0));
    check("mid_rst_busy",   512'(busy),        512'(1'b0));
    check("mid_rst_ready",  512'(start_ready), 512'(1'b1));
    check("mid_rst_ks",     keystream,         '0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 512'(ks_valid), 512'(1'b0));
    start_req(rfc_key, rfc_nonce, 32'd1);
    lat = 0;
    wait_valid(lat);
    check("post_rst_lat",   512'(lat), 512'(21));
    check("post_rst_block", keystream, rfc_exp);
    xfer();

    // ChaCha8 build on the RFC stimulus and one random stimulus.
    for (int t = 0; t < 2; t++) begin
      rk = (t == 0) ? rfc_key : rand_key();
      rn = (t == 0) ? rfc_nonce : {$urandom, $urandom, $urandom};
      rc = (t == 0) ? 32'd1 : $urandom;
      check("r8_ready", 512'(start_ready8), 512'(1'b1));
      key = rk; nonce = rn; counter = rc; start_valid8 = 1'b1;
      tick();
      start_valid8 = 1'b0;
      lat = 0;
      while (!ks_valid8 && lat < 200) begin tick(); lat++; end
      check("r8_latency", 512'(lat), 512'(9));
      check("r8_block",   keystream8, ref_block(rk, rn, rc, 8));
      ks_ready8 = 1'b1;
      tick();
      ks_ready8 = 1'b0;
      check("r8_valid_drop", 512'(ks_valid8), 512'(1'b0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
